packet_tx_sequencer: RTL and testbench

PACKET_TX_SEQUENCER -- requirements
Module: packet_tx_sequencer

---
 rtl/bpsk_pkg.sv | 20 ++
 rtl/symbol_timer.sv | 31 +++
 rtl/packet_tx_sequencer.sv | 168 ++++++++++++++++
 tb/tb_packet_tx_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK packet transmitter: FSM states and framing bytes.
package bpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_GAP      = 3'd4
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SYNC_BYTE     = 8'h7E;

  // True in the states that put frame bits on the line.
  function automatic logic is_sending(input tx_state_t s);
    return (s == ST_PREAMBLE) || (s == ST_SYNC) || (s == ST_PAYLOAD);
  endfunction

endpackage

// File: rtl/symbol_timer.sv
// Bit-period divider: counts SYMBOL_DIV clocks per bit and flags the last
// cycle of each period so the sequencer can advance on the following edge.
module symbol_timer #(
  parameter int SYMBOL_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(SYMBOL_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Divider counter, restarted whenever a frame starts or is cancelled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick = run && !clear && (div_cnt == LAST);

endmodule

// File: rtl/packet_tx_sequencer.sv
// Serialises preamble, sync byte and a latched payload MSB-first, one bit per
// SYMBOL_DIV clocks, followed by an enforced inter-frame gap.
module packet_tx_sequencer
  import bpsk_pkg::*;
#(
  parameter int PACKET_WIDTH   = 4,
  parameter int PREAMBLE_BYTES = 2,
  parameter int SYMBOL_DIV     = 16,
  parameter int GAP_CYCLES     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PACKET_WIDTH-1:0][7:0] packet_in,
  input  logic                         packet_valid,
  input  logic                         tx_enable,
  input  logic                         abort,
  output logic                         packet_ack,
  output logic                         bit_out,
  output logic                         bit_strobe,
  output logic                         tx_active,
  output logic                         frame_done,
  output logic [7:0]                   overrun_count
);

  localparam int MAX_BYTES = (PREAMBLE_BYTES > PACKET_WIDTH) ? PREAMBLE_BYTES : PACKET_WIDTH;
  localparam int BYTE_W    = $clog2(MAX_BYTES + 1);
  localparam int GAP_W     = $clog2(GAP_CYCLES + 1);

  localparam logic [BYTE_W-1:0] LAST_PRE     = BYTE_W'(PREAMBLE_BYTES - 1);
  localparam logic [BYTE_W-1:0] LAST_PAYLOAD = BYTE_W'(PACKET_WIDTH - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP     = GAP_W'(GAP_CYCLES - 1);

  tx_state_t                    state;
  logic [PACKET_WIDTH-1:0][7:0] payload_sr;
  logic [7:0]                   cur_byte;
  logic [7:0]                   next_byte;
  logic [2:0]                   bit_idx;
  logic [BYTE_W-1:0]            byte_idx;
  logic [GAP_W-1:0]             gap_cnt;
  logic                         sending;
  logic                         accept;
  logic                         abort_now;
  logic                         drop;
  logic                         tick;

  assign sending   = is_sending(state);
  assign accept    = (state == ST_IDLE) && packet_valid && tx_enable && !abort;
  assign abort_now = sending && abort;
  // Abort beats acceptance in IDLE, so a coinciding valid counts as lost.
  assign drop      = packet_valid && ((state != ST_IDLE) || (tx_enable && abort));

  symbol_timer #(
    .SYMBOL_DIV(SYMBOL_DIV)
  ) u_symbol_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept || abort_now),
    .run  (sending),
    .tick (tick)
  );

  // Byte to load when the current byte finishes (payload is consumed from byte 0 upward).
  always_comb begin
    next_byte = 8'h00;
    case (state)
      ST_PREAMBLE: next_byte = (byte_idx == LAST_PRE) ? SYNC_BYTE : PREAMBLE_BYTE;
      ST_SYNC,
      ST_PAYLOAD:  next_byte = payload_sr[0];
      default:     next_byte = 8'h00;
    endcase
  end

  // Frame sequencer: state, bit/byte position and all registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      payload_sr <= '0;
      cur_byte   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      packet_ack <= 1'b0;
      bit_out    <= 1'b0;
      bit_strobe <= 1'b0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      packet_ack <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_PREAMBLE;
            payload_sr <= packet_in;
            cur_byte   <= PREAMBLE_BYTE;
            bit_out    <= PREAMBLE_BYTE[7];
            bit_idx    <= '0;
            byte_idx   <= '0;
            packet_ack <= 1'b1;
            bit_strobe <= 1'b1;
            tx_active  <= 1'b1;
          end
        end
        ST_PREAMBLE, ST_SYNC, ST_PAYLOAD: begin
          if (abort) begin
            state     <= ST_GAP;
            gap_cnt   <= '0;
            bit_out   <= 1'b0;
            tx_active <= 1'b0;
          end else if (tick) begin
            if (bit_idx != 3'd7) begin
              bit_idx    <= bit_idx + 3'd1;
              cur_byte   <= {cur_byte[6:0], 1'b0};
              bit_out    <= cur_byte[6];
              bit_strobe <= 1'b1;
            end else if ((state == ST_PAYLOAD) && (byte_idx == LAST_PAYLOAD)) begin
              state      <= ST_GAP;
              gap_cnt    <= '0;
              bit_idx    <= '0;
              bit_out    <= 1'b0;
              tx_active  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              bit_idx    <= '0;
              cur_byte   <= next_byte;
              bit_out    <= next_byte[7];
              bit_strobe <= 1'b1;
              if (state == ST_PREAMBLE) begin
                if (byte_idx == LAST_PRE) begin
                  state    <= ST_SYNC;
                  byte_idx <= '0;
                end else begin
                  byte_idx <= byte_idx + 1'b1;
                end
              end else if (state == ST_SYNC) begin
                state      <= ST_PAYLOAD;
                byte_idx   <= '0;
                payload_sr <= payload_sr >> 8;
              end else begin
                byte_idx   <= byte_idx + 1'b1;
                payload_sr <= payload_sr >> 8;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of packets offered while the sequencer could not take them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_count <= 8'd0;
    end else if (drop && (overrun_count != 8'hFF)) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_packet_tx_sequencer.sv
// Self-checking bench for packet_tx_sequencer: directed scenarios with random
// payloads compared against a frame-level model of the expected line activity.
module tb_packet_tx_sequencer;

  localparam int PW          = 4;
  localparam int PB          = 2;
  localparam int SD          = 16;
  localparam int GAPC        = 32;
  localparam int FRAME_BYTES = PB + 1 + PW;
  localparam int FRAME_CYC   = 8 * FRAME_BYTES * SD;
  localparam int SYNC_START  = 8 * PB * SD;
  localparam int PAY_START   = 8 * (PB + 1) * SD;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PW-1:0][7:0] packet_in = '0;
  logic               packet_valid = 1'b0;
  logic               tx_enable = 1'b0;
  logic               abort = 1'b0;
  logic               packet_ack;
  logic               bit_out;
  logic               bit_strobe;
  logic               tx_active;
  logic               frame_done;
  logic [7:0]         overrun_count;

  int checks  = 0;
  int errors  = 0;
  int exp_ovr = 0;

  packet_tx_sequencer #(
    .PACKET_WIDTH  (PW),
    .PREAMBLE_BYTES(PB),
    .SYMBOL_DIV    (SD),
    .GAP_CYCLES    (GAPC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .packet_in    (packet_in),
    .packet_valid (packet_valid),
    .tx_enable    (tx_enable),
    .abort        (abort),
    .packet_ack   (packet_ack),
    .bit_out      (bit_out),
    .bit_strobe   (bit_strobe),
    .tx_active    (tx_active),
    .frame_done   (frame_done),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bit n of the frame: preamble bytes, sync byte, then payload byte 0 upward, MSB first.
  function automatic logic model_bit(input logic [PW-1:0][7:0] data, input int n);
    int         byte_no;
    logic [7:0] b;
    byte_no = n / 8;
    if (byte_no < PB)       b = 8'hAA;
    else if (byte_no == PB) b = 8'h7E;
    else                    b = data[byte_no - PB - 1];
    return b[7 - (n % 8)];
  endfunction

  function automatic logic [PW-1:0][7:0] rand_payload();
    logic [PW-1:0][7:0] d;
    for (int i = 0; i < PW; i++) d[i] = 8'($urandom);
    return d;
  endfunction

  // Called at a negedge with the DUT idle. Offers one packet, then watches the
  // frame and the following gap cycle by cycle. k = 0 is the cycle after the
  // accepting edge. Optional: abort at cycle abort_at, drop_n extra valids from
  // drop_at, tx_enable low from txen_low_at, an ignored abort inside the gap.
  task automatic send_frame(input logic [PW-1:0][7:0] data, input int abort_at,
                            input int drop_at, input int drop_n,
                            input int txen_low_at, input bit gap_abort);
    int       end_len, mism, strobes, act_cyc, dones, acks;
    logic     eb;
    logic [4:0] obs, expv;
    end_len = (abort_at >= 0) ? abort_at + 1 : FRAME_CYC;
    packet_in    = data;
    packet_valid = 1'b1;
    tx_enable    = 1'b1;
    abort        = 1'b0;
    @(negedge clk);
    packet_valid = 1'b0;
    mism = 0; strobes = 0; act_cyc = 0; dones = 0; acks = 0;
    for (int k = 0; k < end_len + GAPC; k++) begin
      eb   = (k < end_len) ? model_bit(data, k / SD) : 1'b0;
      expv = {k == 0, k < end_len, eb, (k < end_len) && (k % SD == 0),
              (abort_at < 0) && (k == end_len)};
      obs  = {packet_ack, tx_active, bit_out, bit_strobe, frame_done};
      if (obs !== expv) mism++;
      strobes += int'(bit_strobe);
      act_cyc += int'(tx_active);
      dones   += int'(frame_done);
      acks    += int'(packet_ack);
      packet_valid = (drop_n > 0) && (k >= drop_at) && (k < drop_at + drop_n);
      packet_in    = packet_valid ? ~data : data;
      if (packet_valid && exp_ovr < 255) exp_ovr++;
      abort     = (k == abort_at) || (gap_abort && (k == end_len + 3));
      tx_enable = !((txen_low_at >= 0) && (k >= txen_low_at));
      @(negedge clk);
    end
    packet_valid = 1'b0;
    abort        = 1'b0;
    check("frame_cycle_mismatches", mism, 0);
    check("strobe_count", strobes, (end_len + SD - 1) / SD);
    check("tx_active_cycles", act_cyc, end_len);
    check("frame_done_pulses", dones, (abort_at < 0) ? 1 : 0);
    check("ack_pulses", acks, 1);
    check("overrun_count", int'(overrun_count), exp_ovr);
  endtask

  initial begin
    int ab;

    // Reset state
    #2;
    check("reset_outputs", int'({packet_ack, bit_out, bit_strobe, tx_active, frame_done}), 0);
    check("reset_overrun", int'(overrun_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Valid with tx_enable low is ignored entirely
    packet_in    = rand_payload();
    packet_valid = 1'b1;
    tx_enable    = 1'b0;
    @(negedge clk);
    packet_valid = 1'b0;
    check("txen_low_ack", int'(packet_ack), 0);
    check("txen_low_active", int'(tx_active), 0);
    check("txen_low_overrun", int'(overrun_count), exp_ovr);
    @(negedge clk);

    // Reference frame: payload 01 02 03 04
    send_frame(32'h04030201, -1, -1, 0, -1, 1'b0);

    // One drop mid-payload leaves the frame intact
    send_frame(rand_payload(), -1, PAY_START + int'($urandom_range(0, 500)), 1, -1, 1'b0);

    // Abort coinciding with valid in IDLE drops the packet
    packet_in    = rand_payload();
    packet_valid = 1'b1;
    tx_enable    = 1'b1;
    abort        = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;
    abort        = 1'b0;
    exp_ovr++;
    check("idle_abort_ack", int'(packet_ack), 0);
    check("idle_abort_active", int'(tx_active), 0);
    check("idle_abort_overrun", int'(overrun_count), exp_ovr);
    @(negedge clk);

    // Abort during SYNC; abort in GAP ignored; valid in last gap cycle dropped
    ab = SYNC_START + int'($urandom_range(0, 8 * SD - 1));
    send_frame(rand_payload(), ab, ab + GAPC, 1, -1, 1'b1);

    // Accepted in the first idle cycle after the gap; tx_enable dropped mid-frame
    send_frame(rand_payload(), -1, -1, 0, int'($urandom_range(1, FRAME_CYC - 50)), 1'b0);

    // 300 drops mid-payload saturate the overrun counter
    send_frame(rand_payload(), -1, PAY_START + 16, 300, -1, 1'b0);
    check("overrun_saturated", int'(overrun_count), 255);

    // Asynchronous reset in the middle of the preamble
    packet_in    = rand_payload();
    packet_valid = 1'b1;
    tx_enable    = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_active", int'(tx_active), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({packet_ack, bit_out, bit_strobe, tx_active, frame_done}), 0);
    check("async_reset_overrun", int'(overrun_count), 0);
    exp_ovr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", int'({packet_ack, tx_active, frame_done}), 0);
    send_frame(rand_payload(), -1, -1, 0, -1, 1'b0);

    // One more plain random frame
    send_frame(rand_payload(), -1, -1, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
